resistive_mixer_sequencer: RTL and testbench

- Time-multiplexed N-way weighted audio mixer. It models a resistor-summing node by sharing one 16x16 multiplier across all inputs.
- On each audio_clk_en it snapshots the inputs, runs a multiply-accumulate sequence over N_INPUTS channels, then scales, saturates and registers the result.
- Per-input weights are runtime-configurable through a shadow register bank, so a discrete-audio top level can retune the mix without resynthesis.

---
 rtl/resistive_mixer_sequencer.sv | 145 ++++++++++++++
 tb/tb_resistive_mixer_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/resistive_mixer_sequencer.sv
// Time-multiplexed N-way weighted audio mixer.
// One 16x16 multiplier is shared across all channels: each sample strobe
// snapshots the inputs, runs a MAC pass over the channels, then
// scales (>>16), saturates and registers the mixed output.
module resistive_mixer_sequencer #(
  parameter int N_INPUTS = 4,
  parameter int IDX_W    = $clog2(N_INPUTS),
  parameter int ACC_W    = 32 + $clog2(N_INPUTS)
) (
  input  logic             clk,
  input  logic             I_RST,
  input  logic             audio_clk_en,
  input  logic [15:0]      inputs [N_INPUTS-1:0],
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [15:0]      cfg_wdata,
  output logic [15:0]      out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam logic [15:0]      W_DEF    = 16'(65536 / N_INPUTS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [ACC_W-1:0] acc_q,     acc_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [15:0]      snap_q     [N_INPUTS-1:0];
  logic [15:0]      snap_d     [N_INPUTS-1:0];
  logic [15:0]      shadow_q   [N_INPUTS-1:0];
  logic [15:0]      shadow_d   [N_INPUTS-1:0];
  logic [15:0]      w_act_q    [N_INPUTS-1:0];
  logic [15:0]      w_act_d    [N_INPUTS-1:0];
  logic [15:0]      out_q,     out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,    busy_d;
  logic             overrun_q, overrun_d;
  logic [31:0]      prod;

  // Shared multiplier: current snapshot channel times its active weight.
  always_comb begin
    prod = 32'(snap_q[idx_q]) * 32'(w_act_q[idx_q]);
  end

  // Next-state, datapath and output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    w_act_d     = w_act_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    // busy lags the state by one edge so it covers the MAC and DONE cycles
    // shifted onto the registered-output timeline.
    busy_d      = (state_q != IDLE);

    // Shadow bank accepts writes in any state; addresses beyond the last
    // channel never match the loop index and are dropped.
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (cfg_we && (32'(cfg_addr) == i)) begin
        shadow_d[i] = cfg_wdata;
      end
    end

    case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          snap_d  = inputs;
          // Copy the post-write shadow so a same-cycle write is included.
          w_act_d = shadow_d;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (audio_clk_en) begin
          overrun_d = 1'b1;
        end
        acc_d = acc_q + ACC_W'(prod);
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (audio_clk_en) begin
          overrun_d = 1'b1;
        end
        // Registered here, so out/out_valid appear on the edge leaving DONE.
        out_d       = (|acc_q[ACC_W-1:32]) ? '1 : acc_q[31:16];
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (I_RST) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        snap_q[i]   <= '0;
        shadow_q[i] <= W_DEF;
        w_act_q[i]  <= W_DEF;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      snap_q      <= snap_d;
      shadow_q    <= shadow_d;
      w_act_q     <= w_act_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_resistive_mixer_sequencer.sv
// Self-checking bench for resistive_mixer_sequencer (N_INPUTS = 4).
module tb_resistive_mixer_sequencer;

  localparam int N = 4;
  localparam int LAT = N + 1;

  logic        clk = 1'b0;
  logic        I_RST;
  logic        audio_clk_en;
  logic [15:0] din [N-1:0];
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [15:0] exp_q [$];
  int          t_q   [$];

  typedef struct packed {
    logic [3:0][15:0] in_v;
    logic [3:0][15:0] w;
    logic [15:0]      exp;
  } vec_t;

  vec_t tbl [8];

  resistive_mixer_sequencer #(.N_INPUTS(N)) dut (
    .clk         (clk),
    .I_RST       (I_RST),
    .audio_clk_en(audio_clk_en),
    .inputs      (din),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .out         (out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every out_valid pops one expected value and its strobe edge.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got out_valid=1 out=0x%0h expected no result (cycle %0d)", out, cyc);
      end else begin
        automatic logic [15:0] e = exp_q.pop_front();
        automatic int t = t_q.pop_front();
        check("out", int'(out), int'(e));
        check("latency", cyc - t, LAT);
      end
    end
  end

  // Caller is at a negedge; the strobe is captured on the next posedge.
  task automatic strobe(input logic push, input logic [15:0] exp);
    audio_clk_en = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      t_q.push_back(cyc + 1);
    end
    @(negedge clk);
    audio_clk_en = 1'b0;
    for (int i = 0; i < N; i++) din[i] = 16'($urandom);
  endtask

  task automatic write_w(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !busy && !out_valid) return;
      @(negedge clk);
    end
    n_cmp++;
    n_fail++;
    $display("FAIL timeout: got busy=%0b pending=%0d expected idle", busy, exp_q.size());
    exp_q.delete();
    t_q.delete();
  endtask

  task automatic reset_dut();
    I_RST = 1'b1;
    @(negedge clk);
    I_RST = 1'b0;
    exp_q.delete();
    t_q.delete();
  endtask

  task automatic set_din(input logic [15:0] v);
    for (int i = 0; i < N; i++) din[i] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {in3,in2,in1,in0}, {w3,w2,w1,w0}, expected out
    tbl[0] = '{in_v: {4{16'h8000}}, w: {4{16'h4000}}, exp: 16'h8000};
    tbl[1] = '{in_v: {16'hFFFF, 16'hFFFF, 16'h3000, 16'h1000},
               w: {16'h0000, 16'h0000, 16'h8000, 16'h8000}, exp: 16'h2000};
    tbl[2] = '{in_v: {4{16'hFFFF}}, w: {4{16'hFFFF}}, exp: 16'hFFFF};
    tbl[3] = '{in_v: {4{16'h0000}}, w: {4{16'hFFFF}}, exp: 16'h0000};
    tbl[4] = '{in_v: {16'h0, 16'h0, 16'h0, 16'h4000}, w: {4{16'hFFFF}}, exp: 16'h3FFF};
    tbl[5] = '{in_v: {4{16'h0001}}, w: {16'h0, 16'h0, 16'h0, 16'h1234}, exp: 16'h0000};
    tbl[6] = '{in_v: {4{16'h4000}}, w: {4{16'hFFFF}}, exp: 16'hFFFF};
    tbl[7] = '{in_v: {4{16'h4001}}, w: {4{16'hFFFF}}, exp: 16'hFFFF};

    I_RST = 1'b1;
    audio_clk_en = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    set_din(16'h0);
    repeat (3) @(negedge clk);
    I_RST = 1'b0;

    check("rst_out", int'(out), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);

    // Default weights and busy profile across edges 1..6 after the strobe.
    set_din(16'h8000);
    strobe(1'b1, 16'h8000);
    check("busy_e0", int'(busy), 0);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      check("busy_profile", int'(busy), (k <= LAT) ? 1 : 0);
    end
    wait_done();

    // Table of weight/input combinations.
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < N; c++) write_w(2'(c), tbl[v].w[c]);
      for (int c = 0; c < N; c++) din[c] = tbl[v].in_v[c];
      strobe(1'b1, tbl[v].exp);
      wait_done();
      repeat (3) @(negedge clk);
      check("out_hold", int'(out), int'(tbl[v].exp));
    end

    // Weight write during MAC affects only the next sample.
    reset_dut();
    set_din(16'h8000);
    strobe(1'b1, 16'h8000);
    write_w(2'd0, 16'h0000);
    wait_done();
    set_din(16'h8000);
    strobe(1'b1, 16'h6000);
    wait_done();

    // Same-cycle write at sample start is included in the active copy.
    set_din(16'h8000);
    cfg_we = 1'b1;
    cfg_addr = 2'd0;
    cfg_wdata = 16'h4000;
    strobe(1'b1, 16'h8000);
    cfg_we = 1'b0;
    wait_done();
    write_w(2'd0, 16'h0000);

    // Overrun: second strobe two clocks later is dropped.
    check("overrun_pre", int'(overrun), 0);
    set_din(16'h8000);
    strobe(1'b1, 16'h6000);
    @(negedge clk);
    strobe(1'b0, 16'h0000);
    wait_done();
    check("overrun_set", int'(overrun), 1);
    set_din(16'h8000);
    strobe(1'b1, 16'h6000);
    wait_done();
    check("overrun_sticky", int'(overrun), 1);

    // Reset in the middle of MAC.
    set_din(16'h8000);
    strobe(1'b1, 16'h6000);
    @(negedge clk);
    reset_dut();
    check("midrst_out", int'(out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_valid", int'(out_valid), 0);
    repeat (8) @(negedge clk);
    check("midrst_novalid", int'(out_valid), 0);
    set_din(16'h8000);
    strobe(1'b1, 16'h8000);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
